// File: rtl/mulu_ddr_out_stager.sv
// mulu_ddr_out_stager
//   Upstream feeder for the clock-edge output mux of the mulu_m7q7 multiplier.
//   Full-width products arrive over a valid/ready handshake, wait in a
//   2-entry FIFO and are then presented as two registered halves: `pos`
//   (upper half, driven by the mux while clk is high) and `neg` (lower half,
//   driven while clk is low). Each product is held for HOLD_CYCLES cycles so
//   slow external samplers see both halves.
//
//   Optional feature, macro MULU_DDR_OUT_IDLE_PATTERN_EN:
//     when defined, `pos`/`neg` show an alternating liveness pattern
//     (MSB=1 on `pos`, complement on `neg`) during reset and whenever the
//     stager drops back to IDLE. When undefined, IDLE keeps the last
//     product and the reset value is 0.

module mulu_ddr_out_stager #(
    parameter int WIDTH       = 7,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]   pos,
    output logic [WIDTH-1:0]   neg,
    output logic               out_valid
);

    localparam int PW = 2 * WIDTH;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    // Value loaded into the hold counter when a product is presented; the
    // product then stays on the pins for HOLD_CYCLES cycles in total.
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

`ifdef MULU_DDR_OUT_IDLE_PATTERN_EN
    // Alternating bits with the MSB set, e.g. 7'b1010101 for WIDTH=7.
    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p[i] = (((WIDTH - 1 - i) % 2) == 0);
        end
        return p;
    endfunction

    localparam logic [WIDTH-1:0] IDLE_POS = alt_pattern();
    localparam logic [WIDTH-1:0] IDLE_NEG = ~alt_pattern();
`else
    localparam logic [WIDTH-1:0] IDLE_POS = '0;
    localparam logic [WIDTH-1:0] IDLE_NEG = '0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // ------------------------------------------------------------------
    logic [PW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] head;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // Ready comes from the registered count only, so it never depends on
    // in_valid; reset forces it low so nothing is accepted while clearing.
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // FIFO occupancy and pointers; reset discards everything queued.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of the
    // order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, written only on an accepted transfer.
    // NOTE: the data array has no reset; the count and pointers already mark
    // every entry invalid, so clearing storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          load;

    // Next-state logic: decide when to pop the FIFO and start a new product.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (!empty) begin
                    // Back-to-back: next product follows with no idle gap.
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            hold_d = HOLD_RELOAD;
        end
    end

    // State and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Output halves: registered so they only change on posedge and stay
    // stable for the whole cycle seen by the downstream edge mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= IDLE_POS;
            neg <= IDLE_NEG;
        end else if (load) begin
            pos <= head[PW-1:WIDTH];
            neg <= head[WIDTH-1:0];
        end
`ifdef MULU_DDR_OUT_IDLE_PATTERN_EN
        else if (state_q == SHOW && state_d == IDLE) begin
            // Dropping back to IDLE: switch the pins to the liveness pattern.
            pos <= IDLE_POS;
            neg <= IDLE_NEG;
        end
`endif
    end

    assign out_valid = (state_q == SHOW);

endmodule

// File: tb/tb_mulu_ddr_out_stager.sv
// Directed bench for mulu_ddr_out_stager. Two instances share clock and
// reset: dut1 with HOLD_CYCLES=1 and dut3 with HOLD_CYCLES=3. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.

module tb_mulu_ddr_out_stager;

    localparam int W = 7;

`ifdef MULU_DDR_OUT_IDLE_PATTERN_EN
    localparam logic [W-1:0] RST_POS   = 7'h55;
    localparam logic [W-1:0] RST_NEG   = 7'h2A;
    localparam logic [W-1:0] SGL_IDL_P = 7'h55;
    localparam logic [W-1:0] SGL_IDL_N = 7'h2A;
    localparam logic [W-1:0] C_IDL_P   = 7'h55;
    localparam logic [W-1:0] C_IDL_N   = 7'h2A;
`else
    localparam logic [W-1:0] RST_POS   = 7'h00;
    localparam logic [W-1:0] RST_NEG   = 7'h00;
    localparam logic [W-1:0] SGL_IDL_P = 7'h54;
    localparam logic [W-1:0] SGL_IDL_N = 7'h55;
    localparam logic [W-1:0] C_IDL_P   = 7'h24;
    localparam logic [W-1:0] C_IDL_N   = 7'h34;
`endif

    logic           clk;
    logic           rst;
    logic           v1, r1, ov1;
    logic [2*W-1:0] d1;
    logic [W-1:0]   pos1, neg1;
    logic           v3, r3, ov3;
    logic [2*W-1:0] d3;
    logic [W-1:0]   pos3, neg3;

    int n_tests = 0;
    int n_fail  = 0;

    mulu_ddr_out_stager #(.WIDTH(W), .HOLD_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (r1),
        .in_data   (d1),
        .pos       (pos1),
        .neg       (neg1),
        .out_valid (ov1)
    );

    mulu_ddr_out_stager #(.WIDTH(W), .HOLD_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v3),
        .in_ready  (r3),
        .in_data   (d3),
        .pos       (pos3),
        .neg       (neg3),
        .out_valid (ov3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of dut3 followed by a check of all its outputs.
    task automatic step3(input string tag, input logic [W-1:0] ep, input logic [W-1:0] en,
                         input logic eo, input logic er);
        tick();
        check({tag, "_pos"}, 32'(pos3), 32'(ep));
        check({tag, "_neg"}, 32'(neg3), 32'(en));
        check({tag, "_ov"},  32'(ov3),  32'(eo));
        check({tag, "_rdy"}, 32'(r3),   32'(er));
    endtask

    logic [2*W-1:0] sb[$];
    int             n_sent;
    int             seen;
    logic           adv;

    initial begin
        rst = 1'b1;
        v1  = 1'b0;
        d1  = '0;
        v3  = 1'b0;
        d3  = '0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_rdy1", 32'(r1), 0);
        check("rst_rdy3", 32'(r3), 0);
        check("rst_pos1", 32'(pos1), 32'(RST_POS));
        check("rst_neg1", 32'(neg1), 32'(RST_NEG));
        check("rst_ov1",  32'(ov1), 0);
        check("rst_ov3",  32'(ov3), 0);
        rst = 1'b0;
        #1;
        check("rel_rdy1", 32'(r1), 1);
        check("rel_rdy3", 32'(r3), 1);

        // ---- single product through dut1 (HOLD_CYCLES=1) ----
        v1 = 1'b1;
        d1 = 14'h2A55;
        tick();                                   // edge N: pushed
        v1 = 1'b0;
        d1 = '0;
        check("sgl_n_ov", 32'(ov1), 0);
        tick();                                   // edge N+1: presented
        check("sgl_n1_pos", 32'(pos1), 32'h54);
        check("sgl_n1_neg", 32'(neg1), 32'h55);
        check("sgl_n1_ov",  32'(ov1), 1);
        tick();                                   // edge N+2: back to IDLE
        check("sgl_n2_ov",  32'(ov1), 0);
        check("sgl_n2_pos", 32'(pos1), 32'(SGL_IDL_P));
        check("sgl_n2_neg", 32'(neg1), 32'(SGL_IDL_N));

        // ---- HOLD_CYCLES=3: 3FFF, 0001, 1234 pushed back to back ----
        v3 = 1'b1;
        d3 = 14'h3FFF;
        step3("h3_e1", RST_POS, RST_NEG, 1'b0, 1'b1);
        d3 = 14'h0001;
        step3("h3_e2", 7'h7F, 7'h7F, 1'b1, 1'b1);
        d3 = 14'h1234;
        step3("h3_e3", 7'h7F, 7'h7F, 1'b1, 1'b0);  // two queued: not ready
        v3 = 1'b0;
        d3 = '0;
        step3("h3_e4",  7'h7F, 7'h7F, 1'b1, 1'b0);
        step3("h3_e5",  7'h00, 7'h01, 1'b1, 1'b1);  // no gap after 3 cycles
        step3("h3_e6",  7'h00, 7'h01, 1'b1, 1'b1);
        step3("h3_e7",  7'h00, 7'h01, 1'b1, 1'b1);
        step3("h3_e8",  7'h24, 7'h34, 1'b1, 1'b1);
        step3("h3_e9",  7'h24, 7'h34, 1'b1, 1'b1);
        step3("h3_e10", 7'h24, 7'h34, 1'b1, 1'b1);
        step3("h3_e11", C_IDL_P, C_IDL_N, 1'b0, 1'b1);

        // ---- reset while showing with two products queued ----
        v3 = 1'b1;
        d3 = 14'h3FFF;
        step3("mr_e1", C_IDL_P, C_IDL_N, 1'b0, 1'b1);
        d3 = 14'h0001;
        step3("mr_e2", 7'h7F, 7'h7F, 1'b1, 1'b1);
        d3 = 14'h1234;
        step3("mr_e3", 7'h7F, 7'h7F, 1'b1, 1'b0);
        v3 = 1'b0;
        d3 = '0;
        step3("mr_e4", 7'h7F, 7'h7F, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("mr_rst_rdy", 32'(r3), 0);
        step3("mr_rst", RST_POS, RST_NEG, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mr_rel_rdy", 32'(r3), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mr_stale_ov",  32'(ov3), 0);
            check("mr_stale_pos", 32'(pos3), 32'(RST_POS));
        end

        // ---- 20 random products, in_valid held high, FIFO fills ----
        n_sent = 0;
        seen   = 0;
        v3     = 1'b1;
        d3     = 14'($urandom);
        for (int cyc = 0; cyc < 300 && !(n_sent == 20 && sb.size() == 0); cyc++) begin
            adv = 1'b0;
            if (v3 && r3) begin
                sb.push_back(d3);
                n_sent++;
                adv = 1'b1;
            end
            tick();
            if (ov3) begin
                if (sb.size() == 0) begin
                    check("rand_extra_ov", 32'(ov3), 0);
                end else begin
                    check("rand_data", 32'({pos3, neg3}), 32'(sb[0]));
                    seen++;
                    if (seen == 3) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
            if (adv) begin
                if (n_sent < 20) begin
                    d3 = 14'($urandom);
                end else begin
                    v3 = 1'b0;
                    d3 = '0;
                end
            end
        end
        check("rand_sent",    32'(n_sent), 20);
        check("rand_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mulu_ddr_out_stager.md
Name: mulu_ddr_out_stager

Overview:
- Upstream feeder for the clock-edge output mux of the mulu_m7q7 multiplier.
- Accepts full-width products over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents each product as two registered halves, `pos` (upper) and `neg` (lower). Both are stable for whole clock cycles, so the mux downstream can drive `pos` during clk-high and `neg` during clk-low.
- Holds each product for a programmable number of cycles so slow external samplers see both halves.

Parameters:
- WIDTH, 7, width of one half (output pin count); product width is 2*WIDTH.
- HOLD_CYCLES, 1, cycles each product is presented (must be >=1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product available.
- in_ready  output  1  stager can accept a product this cycle.
- in_data  input  2*WIDTH  product; upper half goes to `pos`, lower half to `neg`.
- pos  output  WIDTH  registered upper half; feeds the mux `pos` input.
- neg  output  WIDTH  registered lower half; feeds the mux `neg` input.
- out_valid  output  1  high while `pos`/`neg` carry a real product.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high; no other clock or reset.
- Reset values:
  - `pos`=0, `neg`=0, `out_valid`=0.
  - FIFO count=0, hold counter=0, state=IDLE.
  - `in_ready`=0 while `rst` is high; `in_ready`=1 on the first cycle after release.
- Reset mid-operation discards FIFO contents and the current presentation.
- Handshake:
  - `in_ready` = !full && !rst (combinational from registered count).
  - Transfer on any posedge with `in_valid` && `in_ready`.
  - `in_data` is sampled only on transfer.
  - When full, no push occurs even if a pop happens the same cycle.
  - With count=1, simultaneous push and pop is legal and count stays 1.
- FIFO: 2 entries, write/read pointers wrap modulo 2, order preserved. Never overflows or underflows.
- States:
  - IDLE: `out_valid`=0. If FIFO is non-empty, pop the head, load `pos`=head[2W-1:W] and `neg`=head[W-1:0], set hold=HOLD_CYCLES-1, go to SHOW.
  - SHOW: `out_valid`=1. If hold>0, decrement and keep `pos`/`neg`. If hold==0 and FIFO is non-empty, pop and load the next product back-to-back (no idle gap), reload hold. If hold==0 and FIFO is empty, go to IDLE.
- Latency:
  - A product accepted at edge N into an empty stager is pushed at N and loaded to `pos`/`neg` at edge N+1.
  - It is presented for exactly HOLD_CYCLES cycles.
- Sustained throughput: one product per HOLD_CYCLES cycles.
- IDLE output value: `pos`/`neg` retain the last presented product (0 after reset) unless the optional feature is enabled.
- Hold counter: width $clog2(HOLD_CYCLES+1). HOLD_CYCLES=1 means no countdown; a new load is possible every cycle.
- `pos`/`neg` change only on posedge (glitch-free across the whole cycle, as the downstream mux requires).

Optional Feature:
- Macro: MULU_DDR_OUT_IDLE_PATTERN_EN.
- Enabled: on entry to IDLE, and during reset, `pos` is driven to the alternating pattern with MSB=1 (WIDTH=7: 7'b1010101) and `neg` to its complement (7'b0101010). The pins then toggle every half-cycle as a liveness marker. `out_valid` stays 0.
- Disabled: IDLE holds the last product; reset value is 0.

Test Plan:
- Reset release, WIDTH=7, HOLD_CYCLES=1: `in_ready` is 0 during `rst`, 1 on the next cycle; `pos`=0, `neg`=0, `out_valid`=0.
- Single product 14'h2A55 accepted at edge N: at edge N+1, `pos`=7'h54, `neg`=7'h55, `out_valid`=1. At N+2 the stager returns to IDLE with `out_valid`=0 and values held.
- HOLD_CYCLES=3, push 14'h3FFF then 14'h0001 on consecutive cycles:
  - 7F/7F is held 3 cycles, then 00/01 is held 3 cycles with no gap.
  - `in_ready` deasserts when 2 entries are queued.
- Full FIFO with `in_valid` held high: no data loss or duplication; output order matches input order over 20 random products.
- Reset asserted while in SHOW with 2 queued: next cycle all outputs are at reset values, FIFO is empty, and no stale product appears afterwards.
- With MULU_DDR_OUT_IDLE_PATTERN_EN: after reset, `pos`=7'b1010101 and `neg`=7'b0101010. After one product finishes, the outputs return to the pattern while `out_valid`=0.
